lock_buzzer_arbiter: RTL and testbench



---
 rtl/lock_buzzer_if.sv | 38 +++
 rtl/lock_buzzer_arbiter.sv | 168 ++++++++++++++++
 tb/tb_lock_buzzer_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/lock_buzzer_if.sv
// Bus between the keypad/password datapath and the buzzer arbiter.
//
// Signals:
//   en          datapath -> arbiter  buzzer enable; low mutes and aborts
//   req_key     datapath -> arbiter  one-cycle key-press event pulse
//   req_pass    datapath -> arbiter  one-cycle correct-password event pulse
//   req_fail    datapath -> arbiter  one-cycle wrong-password event pulse
//   buzzer      arbiter -> pin       registered square-wave buzzer drive
//   busy        arbiter -> datapath  a tone pattern is running
//   active_src  arbiter -> datapath  00 none, 01 key, 10 pass, 11 fail
//   done        arbiter -> datapath  one-cycle pulse on normal completion
//   dbg_state   arbiter -> observer  raw FSM state encoding
//
// Handshake: requests are fire-and-forget pulses. There is no ready. A pulse
// is either accepted on the edge that samples it or dropped for good. A pulse
// is dropped if en is low, a higher-priority request arrives in the same
// cycle, or a higher-priority pattern is running. Nothing is queued.
interface lock_buzzer_if;
  logic       en;
  logic       req_key;
  logic       req_pass;
  logic       req_fail;
  logic       buzzer;
  logic       busy;
  logic [1:0] active_src;
  logic       done;
  logic [2:0] dbg_state;

  modport master (
    output en, req_key, req_pass, req_fail,
    input  buzzer, busy, active_src, done, dbg_state
  );

  modport slave (
    input  en, req_key, req_pass, req_fail,
    output buzzer, busy, active_src, done, dbg_state
  );
endinterface

// File: rtl/lock_buzzer_arbiter.sv
// Fixed-priority arbiter for the keypad-lock buzzer. The priority order is
// fail, then pass, then key. It runs a timed tone pattern for the winning
// source and drives the buzzer pin from a register.
//
// Ports:
//   clk  system clock
//   RST  synchronous active-high reset
//   bus  lock_buzzer_if.slave (en, requests in; buzzer, busy, active_src,
//        done, dbg_state out)
//
// Patterns:
//   KEY  : tone with period 2*KEY_HALF, lasting KEY_LEN cycles.
//   PASS : tone with period 2*PASS_HALF, lasting PASS_LEN cycles.
//   FAIL : tone for FAIL_SEG cycles, then silence for FAIL_SEG cycles, then
//          tone for FAIL_SEG cycles. Tone period is 2*FAIL_HALF.
module lock_buzzer_arbiter #(
  parameter int unsigned KEY_HALF  = 50000,
  parameter int unsigned KEY_LEN   = 10000000,
  parameter int unsigned PASS_HALF = 25000,
  parameter int unsigned PASS_LEN  = 30000000,
  parameter int unsigned FAIL_HALF = 100000,
  parameter int unsigned FAIL_SEG  = 5000000
) (
  input  logic          clk,
  input  logic          RST,
  lock_buzzer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_KEY      = 3'd1,
    S_PASS     = 3'd2,
    S_FAIL_ON1 = 3'd3,
    S_FAIL_GAP = 3'd4,
    S_FAIL_ON2 = 3'd5
  } state_e;

  localparam logic [31:0] KEY_HALF_M1  = 32'(KEY_HALF - 1);
  localparam logic [31:0] KEY_LEN_M1   = 32'(KEY_LEN - 1);
  localparam logic [31:0] PASS_HALF_M1 = 32'(PASS_HALF - 1);
  localparam logic [31:0] PASS_LEN_M1  = 32'(PASS_LEN - 1);
  localparam logic [31:0] FAIL_HALF_M1 = 32'(FAIL_HALF - 1);
  localparam logic [31:0] FAIL_SEG_M1  = 32'(FAIL_SEG - 1);

  state_e      state_q, state_d;
  logic        buzzer_q, buzzer_d;
  logic        done_q, done_d;
  logic [31:0] half_q, half_d;
  logic [31:0] dur_q, dur_d;

  // Priority levels: 0 none, 1 key, 2 pass, 3 fail.
  logic [1:0]  req_lvl;
  logic [1:0]  cur_lvl;
  logic [31:0] half_m1;
  logic [31:0] len_m1;

  always_comb begin
    req_lvl = 2'd0;
    if (bus.req_fail)      req_lvl = 2'd3;
    else if (bus.req_pass) req_lvl = 2'd2;
    else if (bus.req_key)  req_lvl = 2'd1;
  end

  // The running source's level. This also serves as active_src.
  always_comb begin
    cur_lvl = 2'd0;
    half_m1 = FAIL_HALF_M1;
    len_m1  = FAIL_SEG_M1;
    case (state_q)
      S_KEY:  begin cur_lvl = 2'd1; half_m1 = KEY_HALF_M1;  len_m1 = KEY_LEN_M1;  end
      S_PASS: begin cur_lvl = 2'd2; half_m1 = PASS_HALF_M1; len_m1 = PASS_LEN_M1; end
      S_FAIL_ON1, S_FAIL_GAP, S_FAIL_ON2: cur_lvl = 2'd3;
      default: cur_lvl = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q  <= S_IDLE;
      buzzer_q <= 1'b0;
      done_q   <= 1'b0;
      half_q   <= 32'd0;
      dur_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      buzzer_q <= buzzer_d;
      done_q   <= done_d;
      half_q   <= half_d;
      dur_q    <= dur_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    buzzer_d = buzzer_q;
    done_d   = 1'b0;
    half_d   = half_q;
    dur_d    = dur_q;

    if (!bus.en) begin
      // A mute aborts without a done pulse. It also beats a same-cycle request.
      state_d  = S_IDLE;
      buzzer_d = 1'b0;
      half_d   = 32'd0;
      dur_d    = 32'd0;
    end else if (req_lvl != 2'd0 && req_lvl >= cur_lvl) begin
      // An equal-level request restarts the pattern. A higher-level request
      // preempts the running one. The preempted pattern gets no done pulse.
      case (req_lvl)
        2'd3:    state_d = S_FAIL_ON1;
        2'd2:    state_d = S_PASS;
        default: state_d = S_KEY;
      endcase
      buzzer_d = 1'b1;
      half_d   = 32'd0;
      dur_d    = 32'd0;
    end else begin
      case (state_q)
        S_KEY, S_PASS, S_FAIL_ON1, S_FAIL_ON2: begin
          if (half_q == half_m1) begin
            buzzer_d = ~buzzer_q;
            half_d   = 32'd0;
          end else begin
            half_d = half_q + 32'd1;
          end
          if (dur_q == len_m1) begin
            half_d   = 32'd0;
            dur_d    = 32'd0;
            buzzer_d = 1'b0;
            if (state_q == S_FAIL_ON1) begin
              state_d = S_FAIL_GAP;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            dur_d = dur_q + 32'd1;
          end
        end
        S_FAIL_GAP: begin
          buzzer_d = 1'b0;
          half_d   = 32'd0;
          if (dur_q == FAIL_SEG_M1) begin
            // The second tone segment starts high, like a fresh pattern.
            state_d  = S_FAIL_ON2;
            buzzer_d = 1'b1;
            dur_d    = 32'd0;
          end else begin
            dur_d = dur_q + 32'd1;
          end
        end
        default: begin
          state_d  = S_IDLE;
          buzzer_d = 1'b0;
          half_d   = 32'd0;
          dur_d    = 32'd0;
        end
      endcase
    end
  end

  assign bus.buzzer     = buzzer_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.active_src = cur_lvl;
  assign bus.done       = done_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_lock_buzzer_arbiter.sv
module tb_lock_buzzer_arbiter;

  logic clk;
  logic RST;

  lock_buzzer_if bus ();

  lock_buzzer_arbiter #(
    .KEY_HALF  (2),
    .KEY_LEN   (10),
    .PASS_HALF (1),
    .PASS_LEN  (8),
    .FAIL_HALF (3),
    .FAIL_SEG  (6)
  ) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each vector holds the inputs driven during cycle i and the outputs
  // expected after the edge that closes cycle i.
  typedef struct {
    logic       en;
    logic       k;
    logic       p;
    logic       f;
    logic       bz;
    logic       busy;
    logic [1:0] src;
    logic       done;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_err;

  task automatic add(input logic en, input logic k, input logic p, input logic f,
                     input logic bz, input logic busy, input logic [1:0] src,
                     input logic done);
    vec_t v;
    v.en = en; v.k = k; v.p = p; v.f = f;
    v.bz = bz; v.busy = busy; v.src = src; v.done = done;
    vecs.push_back(v);
  endtask

  // Adds n cycles of a running pattern with no requests. pat lists the
  // buzzer values MSB first.
  task automatic add_busy(input logic [1:0] src, input logic [15:0] pat, input int n);
    for (int i = 0; i < n; i++) add(1'b1, 1'b0, 1'b0, 1'b0, pat[n-1-i], 1'b1, src, 1'b0);
  endtask

  // Driver
  task automatic drive(input logic en, input logic k, input logic p, input logic f);
    bus.en = en; bus.req_key = k; bus.req_pass = p; bus.req_fail = f;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: the expected output words are queued and then compared.
  logic [4:0] exp_q[$];

  task automatic check(input string name, input int idx);
    logic [4:0] exp_w;
    logic [4:0] got_w;
    exp_w = exp_q.pop_front();
    got_w = {bus.buzzer, bus.busy, bus.active_src, bus.done};
    n_vec++;
    if (got_w !== exp_w) begin
      n_err++;
      $display("FAIL %s #%0d: got bz/busy/src/done=%b/%b/%b/%b, want %b/%b/%b/%b",
               name, idx, got_w[4], got_w[3], got_w[2:1], got_w[0],
               exp_w[4], exp_w[3], exp_w[2:1], exp_w[0]);
    end
  endtask

  task automatic expect_out(input logic bz, input logic busy, input logic [1:0] src,
                            input logic done);
    exp_q.push_back({bz, busy, src, done});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    RST = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    step();
    expect_out(1'b0, 1'b0, 2'b00, 1'b0);
    check("reset", 0);
    n_vec++;
    if (bus.dbg_state !== 3'd0) begin
      n_err++;
      $display("FAIL reset_state: got %0d, want 0", bus.dbg_state);
    end
    RST = 1'b0;

    // Key click
    add(1, 1, 0, 0, 1, 1, 2'b01, 0);
    add_busy(2'b01, 16'b1_0011_0011, 9);
    add(1, 0, 0, 0, 0, 0, 2'b00, 1);
    add(1, 0, 0, 0, 0, 0, 2'b00, 0);

    // All three requests at once: fail wins and runs its full pattern
    add(1, 1, 1, 1, 1, 1, 2'b11, 0);
    add_busy(2'b11, 16'b11000, 5);
    add_busy(2'b11, 16'b000000, 6);
    add_busy(2'b11, 16'b111000, 6);
    add(1, 0, 0, 0, 0, 0, 2'b00, 1);
    add(1, 0, 0, 0, 0, 0, 2'b00, 0);

    // Key preempted by pass at cycle 4, then a key request during pass is ignored
    add(1, 1, 0, 0, 1, 1, 2'b01, 0);
    add_busy(2'b01, 16'b100, 3);
    add(1, 0, 1, 0, 1, 1, 2'b10, 0);
    add_busy(2'b10, 16'b01, 2);
    add(1, 1, 0, 0, 0, 1, 2'b10, 0);
    add_busy(2'b10, 16'b1010, 4);
    add(1, 0, 0, 0, 0, 0, 2'b00, 1);
    // A request in the done cycle starts normally: a standalone fail pattern
    add(1, 0, 0, 1, 1, 1, 2'b11, 0);
    add_busy(2'b11, 16'b11000, 5);
    add_busy(2'b11, 16'b000000, 6);
    add_busy(2'b11, 16'b111000, 6);
    add(1, 0, 0, 0, 0, 0, 2'b00, 1);
    add(1, 0, 0, 0, 0, 0, 2'b00, 0);

    // Abort with en=0 at cycle 3. A pass request under en=0 is ignored.
    add(1, 1, 0, 0, 1, 1, 2'b01, 0);
    add_busy(2'b01, 16'b10, 2);
    add(0, 0, 1, 0, 0, 0, 2'b00, 0);
    add(0, 0, 1, 0, 0, 0, 2'b00, 0);
    add(1, 0, 0, 0, 0, 0, 2'b00, 0);

    // Retrigger key at cycle 6
    add(1, 1, 0, 0, 1, 1, 2'b01, 0);
    add_busy(2'b01, 16'b10011, 5);
    add(1, 1, 0, 0, 1, 1, 2'b01, 0);
    add_busy(2'b01, 16'b1_0011_0011, 9);
    add(1, 0, 0, 0, 0, 0, 2'b00, 1);
    add(1, 0, 0, 0, 0, 0, 2'b00, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].k, vecs[i].p, vecs[i].f);
      expect_out(vecs[i].bz, vecs[i].busy, vecs[i].src, vecs[i].done);
      step();
      check("table", i);
    end

    // RST during FAIL_GAP with a request on the reset cycle
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step();
    expect_out(1'b0, 1'b1, 2'b11, 1'b0);
    check("fail_gap", 0);
    RST = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    expect_out(1'b0, 1'b0, 2'b00, 1'b0);
    check("rst_mid", 0);
    n_vec++;
    if (bus.dbg_state !== 3'd0) begin
      n_err++;
      $display("FAIL rst_mid_state: got %0d, want 0", bus.dbg_state);
    end
    RST = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    expect_out(1'b0, 1'b0, 2'b00, 1'b0);
    check("rst_req_dropped", 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    expect_out(1'b1, 1'b1, 2'b01, 1'b0);
    check("post_rst_key", 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
